// File: rtl/i2c_byte_master_if.sv
// -----------------------------------------------------------------------------
// i2c_byte_master_if
// Bus bundle between the single-byte I2C master sequencer and its environment
// (clock-stretch generator, pad, and the requesting logic).
//
// Signals:
//   data_clk    : data-phase clock from the stretch generator
//   start       : transaction request
//   addr[6:0]   : slave address
//   rw          : 0 = write, 1 = read
//   wdata[7:0]  : write byte
//   sda_in      : SDA line value from the pad
//   sda_oe      : 1 pulls SDA low, 0 releases it
//   scl_not_ena : 1 holds SCL high (no stretching), 0 lets SCL toggle
//   busy        : transaction in progress
//   done        : one-cycle end-of-transaction pulse
//   ack_error   : slave NACKed the address or the write byte
//   rdata[7:0]  : byte received in a read
//
// Modports:
//   master : the sequencer itself
//   slave  : everything driving it (generator, pad, requester)
// -----------------------------------------------------------------------------
interface i2c_byte_master_if;
   logic       data_clk;
   logic       start;
   logic [6:0] addr;
   logic       rw;
   logic [7:0] wdata;
   logic       sda_in;
   logic       sda_oe;
   logic       scl_not_ena;
   logic       busy;
   logic       done;
   logic       ack_error;
   logic [7:0] rdata;

   modport master (
      input  data_clk, start, addr, rw, wdata, sda_in,
      output sda_oe, scl_not_ena, busy, done, ack_error, rdata
   );

   modport slave (
      output data_clk, start, addr, rw, wdata, sda_in,
      input  sda_oe, scl_not_ena, busy, done, ack_error, rdata
   );
endinterface

// File: rtl/i2c_byte_master.sv
// -----------------------------------------------------------------------------
// i2c_byte_master
// Single-byte I2C master sequencer. Runs START, 7-bit address + R/W, address
// ACK, one data byte (write or read), ACK/NACK and STOP, stepping on the
// phase edges of data_clk supplied by the clock-stretch generator.
//
// Ports:
//   clk : system clock (shared with the stretch generator)
//   rst : asynchronous active-low reset; releases SDA and SCL at once
//   bus : i2c_byte_master_if.master (request, pad and status signals)
//
// All state changes happen on the rising edge of data_clk (mid SCL-low);
// SDA is sampled on the falling edge of data_clk (mid SCL-high).
// -----------------------------------------------------------------------------
module i2c_byte_master (
   input  logic              clk,
   input  logic              rst,
   i2c_byte_master_if.master bus
);

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_START = 4'd1,
      ST_ADDR  = 4'd2,
      ST_ACK_A = 4'd3,
      ST_WR    = 4'd4,
      ST_ACK_W = 4'd5,
      ST_RD    = 4'd6,
      ST_MNACK = 4'd7,
      ST_STOP  = 4'd8
   } state_t;

   state_t     state_r,     state_nxt_s;
   logic       dc_q_r;
   logic       rise_s;
   logic       fall_s;
   logic [7:0] shreg_r,     shreg_nxt_s;
   logic [2:0] bcnt_r,      bcnt_nxt_s;
   logic [7:0] wdata_r,     wdata_nxt_s;
   logic       rw_r,        rw_nxt_s;
   logic       pending_r,   pending_nxt_s;
   logic       sda_oe_r,    sda_oe_nxt_s;
   logic       scl_ne_r,    scl_ne_nxt_s;
   logic       busy_r,      busy_nxt_s;
   logic       done_r,      done_nxt_s;
   logic       ack_error_r, ack_error_nxt_s;
   logic [7:0] rdata_r,     rdata_nxt_s;

   // rise = mid SCL-low (SDA may change), fall = mid SCL-high (sample SDA)
   assign rise_s = bus.data_clk & ~dc_q_r;
   assign fall_s = ~bus.data_clk & dc_q_r;

   // Delayed copy of data_clk for phase-edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dc_q_r <= 1'b0;
      end else begin
         dc_q_r <= bus.data_clk;
      end
   end

   // State and datapath registers; every output comes straight from here
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         shreg_r     <= 8'h00;
         bcnt_r      <= 3'd0;
         wdata_r     <= 8'h00;
         rw_r        <= 1'b0;
         pending_r   <= 1'b0;
         sda_oe_r    <= 1'b0;
         scl_ne_r    <= 1'b1;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         ack_error_r <= 1'b0;
         rdata_r     <= 8'h00;
      end else begin
         state_r     <= state_nxt_s;
         shreg_r     <= shreg_nxt_s;
         bcnt_r      <= bcnt_nxt_s;
         wdata_r     <= wdata_nxt_s;
         rw_r        <= rw_nxt_s;
         pending_r   <= pending_nxt_s;
         sda_oe_r    <= sda_oe_nxt_s;
         scl_ne_r    <= scl_ne_nxt_s;
         busy_r      <= busy_nxt_s;
         done_r      <= done_nxt_s;
         ack_error_r <= ack_error_nxt_s;
         rdata_r     <= rdata_nxt_s;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt_s     = state_r;
      shreg_nxt_s     = shreg_r;
      bcnt_nxt_s      = bcnt_r;
      wdata_nxt_s     = wdata_r;
      rw_nxt_s        = rw_r;
      pending_nxt_s   = pending_r;
      sda_oe_nxt_s    = sda_oe_r;
      scl_ne_nxt_s    = scl_ne_r;
      busy_nxt_s      = busy_r;
      done_nxt_s      = 1'b0;
      ack_error_nxt_s = ack_error_r;
      rdata_nxt_s     = rdata_r;

      if (rise_s) begin
         case (state_r)
            ST_IDLE: begin
               if (pending_r) begin
                  // SDA falls while SCL is still held high: START condition
                  state_nxt_s   = ST_START;
                  sda_oe_nxt_s  = 1'b1;
                  pending_nxt_s = 1'b0;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_START: begin
               state_nxt_s  = ST_ADDR;
               scl_ne_nxt_s = 1'b0;
               bcnt_nxt_s   = 3'd7;
               sda_oe_nxt_s = ~shreg_r[7];
            end
            ST_ADDR, ST_WR: begin
               if (bcnt_r == 3'd0) begin
                  state_nxt_s  = (state_r == ST_ADDR) ? ST_ACK_A : ST_ACK_W;
                  sda_oe_nxt_s = 1'b0;
               end else begin
                  // shreg[7] is the bit on the wire; [6] is the one to send next
                  shreg_nxt_s  = {shreg_r[6:0], 1'b0};
                  bcnt_nxt_s   = bcnt_r - 3'd1;
                  sda_oe_nxt_s = ~shreg_r[6];
               end
            end
            ST_ACK_A: begin
               if (ack_error_r) begin
                  state_nxt_s  = ST_STOP;
                  sda_oe_nxt_s = 1'b1;
                  scl_ne_nxt_s = 1'b1;
               end else if (rw_r) begin
                  state_nxt_s  = ST_RD;
                  sda_oe_nxt_s = 1'b0;
                  bcnt_nxt_s   = 3'd7;
               end else begin
                  state_nxt_s  = ST_WR;
                  shreg_nxt_s  = wdata_r;
                  sda_oe_nxt_s = ~wdata_r[7];
                  bcnt_nxt_s   = 3'd7;
               end
            end
            ST_RD: begin
               if (bcnt_r == 3'd0) begin
                  // single-byte read ends with a master NACK (SDA released)
                  state_nxt_s  = ST_MNACK;
                  sda_oe_nxt_s = 1'b0;
               end else begin
                  bcnt_nxt_s = bcnt_r - 3'd1;
               end
            end
            ST_ACK_W, ST_MNACK: begin
               // hold SDA low and let SCL return high ahead of the STOP edge
               state_nxt_s  = ST_STOP;
               sda_oe_nxt_s = 1'b1;
               scl_ne_nxt_s = 1'b1;
            end
            ST_STOP: begin
               // SDA rises with SCL high: STOP condition
               state_nxt_s  = ST_IDLE;
               sda_oe_nxt_s = 1'b0;
               busy_nxt_s   = 1'b0;
               done_nxt_s   = 1'b1;
            end
            default: begin
               state_nxt_s   = ST_IDLE;
               sda_oe_nxt_s  = 1'b0;
               scl_ne_nxt_s  = 1'b1;
               busy_nxt_s    = 1'b0;
               pending_nxt_s = 1'b0;
            end
         endcase
      end else if (fall_s) begin
         case (state_r)
            ST_ACK_A, ST_ACK_W: begin
               if (bus.sda_in) begin
                  ack_error_nxt_s = 1'b1;
               end else begin
                  ack_error_nxt_s = ack_error_r;
               end
            end
            ST_RD: begin
               rdata_nxt_s = {rdata_r[6:0], bus.sda_in};
            end
            default: begin
               rdata_nxt_s = rdata_r;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end

      // Requests are only taken while idle with nothing pending; fields stay
      // frozen for the rest of the transaction.
      if ((state_r == ST_IDLE) && !pending_r && bus.start) begin
         shreg_nxt_s     = {bus.addr, bus.rw};
         rw_nxt_s        = bus.rw;
         wdata_nxt_s     = bus.wdata;
         busy_nxt_s      = 1'b1;
         ack_error_nxt_s = 1'b0;
         pending_nxt_s   = 1'b1;
      end else begin
         wdata_nxt_s = wdata_r;
      end
   end

   assign bus.sda_oe      = sda_oe_r;
   assign bus.scl_not_ena = scl_ne_r;
   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.ack_error   = ack_error_r;
   assign bus.rdata       = rdata_r;

endmodule

// File: tb/tb_i2c_byte_master.sv
// -----------------------------------------------------------------------------
// tb_i2c_byte_master
// Self-checking bench for i2c_byte_master. A transaction-level model indexes
// the bus by "slot" (number of data_clk rises since the request was taken) and
// derives the expected SDA/SCL/status values from the slot and the latched
// request. A slave model drives the open-drain SDA line. Directed scenarios
// add literal checks on the serialised bits, rise counts and status values.
// -----------------------------------------------------------------------------
module tb_i2c_byte_master;

   logic clk = 1'b0;
   logic rst;

   i2c_byte_master_if bus ();

   i2c_byte_master dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   // slave behaviour for the current transaction
   logic       cfg_ack_addr = 1'b1;
   logic       cfg_ack_data = 1'b1;
   logic [7:0] cfg_rbyte    = 8'h00;

   // transaction-level model state
   logic       m_busy  = 1'b0;
   logic       m_done  = 1'b0;
   logic       m_ack   = 1'b0;
   logic       m_rw    = 1'b0;
   logic       m_nack  = 1'b0;
   logic [7:0] m_abyte = 8'h00;
   logic [7:0] m_wdata = 8'h00;
   logic [7:0] m_rdata = 8'h00;
   int         slot    = 0;
   int         m_last  = 21;
   int         rises   = 0;
   logic       prev_dc = 1'b0;
   logic       slave_rel;

   // bits seen on the wire, for literal pattern checks
   logic [7:0] cap_addr = 8'h00;
   logic [7:0] cap_data = 8'h00;
   logic       cap_oe19 = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected SDA drive for a slot: 0 pending, 1 START, 2..9 address+rw,
   // 10 address ACK, then either STOP (NACK) or data byte, ACK slot, STOP.
   function automatic logic exp_oe_f(input int s);
      if (s == 0)            return 1'b0;
      else if (s == 1)       return 1'b1;
      else if (s <= 9)       return ~m_abyte[3'(9 - s)];
      else if (s == 10)      return 1'b0;
      else if (m_nack)       return (s == 11);
      else if (s <= 18)      return m_rw ? 1'b0 : ~m_wdata[3'(18 - s)];
      else if (s == 19)      return 1'b0;
      else                   return (s == 20);
   endfunction

   // SCL runs from the first address bit until the STOP slot
   function automatic logic exp_sne_f(input int s);
      if (s <= 1)      return 1'b1;
      else if (m_nack) return (s >= 11);
      else             return (s >= 20);
   endfunction

   // Slave: ACKs by pulling low, returns read data MSB first
   always_comb begin
      slave_rel = 1'b1;
      if (m_busy && !m_nack) begin
         if (slot == 10)                              slave_rel = 1'b0;
         else if ((slot == 19) && !m_rw)              slave_rel = ~cfg_ack_data;
         else if (m_rw && (slot >= 11) && (slot <= 18)) slave_rel = cfg_rbyte[3'(18 - slot)];
         else                                         slave_rel = 1'b1;
      end
   end

   // Open-drain SDA line
   assign bus.sda_in = ~bus.sda_oe & slave_rel;

   // data_clk: 8 clk periods per SCL period
   initial begin
      bus.data_clk = 1'b0;
      forever begin
         repeat (4) @(negedge clk);
         bus.data_clk = ~bus.data_clk;
      end
   end

   // Model update on each clock edge
   initial begin
      logic rise, fall, was_busy;
      forever begin
         @(posedge clk);
         if (rst !== 1'b1) begin
            m_busy = 1'b0; m_done = 1'b0; m_ack = 1'b0; m_rdata = 8'h00;
            slot = 0; prev_dc = 1'b0; rises = 0;
         end else begin
            rise     = bus.data_clk & ~prev_dc;
            fall     = ~bus.data_clk & prev_dc;
            prev_dc  = bus.data_clk;
            was_busy = m_busy;
            m_done   = 1'b0;
            if (rise) rises++;
            if (m_busy && rise) begin
               slot++;
               if (slot == m_last) begin
                  m_busy = 1'b0;
                  m_done = 1'b1;
               end
            end else if (m_busy && fall) begin
               if (((slot == 10) || ((slot == 19) && !m_rw)) && slave_rel) m_ack = 1'b1;
               if (m_rw && !m_nack && (slot >= 11) && (slot <= 18))
                  m_rdata = {m_rdata[6:0], slave_rel};
            end
            if (!was_busy && (bus.start === 1'b1)) begin
               m_busy  = 1'b1;
               slot    = 0;
               rises   = 0;
               m_ack   = 1'b0;
               m_abyte = {bus.addr, bus.rw};
               m_rw    = bus.rw;
               m_wdata = bus.wdata;
               m_nack  = ~cfg_ack_addr;
               m_last  = cfg_ack_addr ? 21 : 12;
            end
         end
      end
   end

   // Per-cycle compare against the model, plus wire-bit capture
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("busy",        32'(bus.busy),        32'(m_busy));
            chk("done",        32'(bus.done),        32'(m_done));
            chk("sda_oe",      32'(bus.sda_oe),      32'(m_busy ? exp_oe_f(slot) : 1'b0));
            chk("scl_not_ena", 32'(bus.scl_not_ena), 32'(m_busy ? exp_sne_f(slot) : 1'b1));
            chk("ack_error",   32'(bus.ack_error),   32'(m_ack));
            chk("rdata",       32'(bus.rdata),       32'(m_rdata));
            if (m_busy && (slot >= 2) && (slot <= 9))   cap_addr[3'(9 - slot)]  = ~bus.sda_oe;
            if (m_busy && (slot >= 11) && (slot <= 18)) cap_data[3'(18 - slot)] = ~bus.sda_oe;
            if (m_busy && (slot == 19))                 cap_oe19 = bus.sda_oe;
         end
      end
   end

   task automatic start_txn(input logic [6:0] a, input logic r, input logic [7:0] w,
                            input logic aa, input logic ad, input logic [7:0] rb);
      cfg_ack_addr = aa;
      cfg_ack_data = ad;
      cfg_rbyte    = rb;
      bus.addr     = a;
      bus.rw       = r;
      bus.wdata    = w;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start    = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            hit = 1'b1;
            break;
         end
      end
      tests++;
      if (!hit) begin
         fails++;
         $display("FAIL %s_done_timeout: got no done, expected done within 400 cycles", name);
      end
   endtask

   task automatic wait_slot(input int n);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (m_busy && (slot == n)) begin
            hit = 1'b1;
            break;
         end
      end
      tests++;
      if (!hit) begin
         fails++;
         $display("FAIL wait_slot: got no slot %0d, expected it within 400 cycles", n);
      end
   endtask

   // Watchdog
   initial begin
      #300000;
      $display("FAIL watchdog: got no finish, expected end of test");
      $fatal(1, "watchdog");
   end

   // Directed scenarios
   initial begin
      rst       = 1'b0;
      bus.start = 1'b0;
      bus.addr  = 7'h00;
      bus.rw    = 1'b0;
      bus.wdata = 8'h00;
      repeat (3) @(negedge clk);

      // reset state
      chk("rst_sda_oe",      32'(bus.sda_oe),      32'd0);
      chk("rst_scl_not_ena", 32'(bus.scl_not_ena), 32'd1);
      chk("rst_busy",        32'(bus.busy),        32'd0);
      chk("rst_done",        32'(bus.done),        32'd0);
      chk("rst_ack_error",   32'(bus.ack_error),   32'd0);
      chk("rst_rdata",       32'(bus.rdata),       32'h00);
      rst    = 1'b1;
      chk_en = 1'b1;
      repeat (5) @(negedge clk);

      // write 0x50 <- 0xA5, both bytes ACKed
      start_txn(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00);
      chk("t1_busy_after_start", 32'(bus.busy), 32'd1);
      wait_done("t1");
      chk("t1_rises",     32'(rises),         32'd21);
      chk("t1_ack_error", 32'(bus.ack_error), 32'd0);
      chk("t1_addr_bits", 32'(cap_addr),      32'hA0);
      chk("t1_data_bits", 32'(cap_data),      32'hA5);
      repeat (7) @(negedge clk);

      // address NACK
      start_txn(7'h3C, 1'b0, 8'h5A, 1'b0, 1'b1, 8'h00);
      wait_done("t2");
      chk("t2_rises",     32'(rises),         32'd12);
      chk("t2_ack_error", 32'(bus.ack_error), 32'd1);
      chk("t2_addr_bits", 32'(cap_addr),      32'h78);
      repeat (5) @(negedge clk);
      chk("t2_ack_error_held", 32'(bus.ack_error), 32'd1);

      // read 0x51, slave returns 0x3C
      start_txn(7'h51, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C);
      wait_done("t3");
      chk("t3_rises",       32'(rises),         32'd21);
      chk("t3_rdata",       32'(bus.rdata),     32'h3C);
      chk("t3_model_rdata", 32'(m_rdata),       32'h3C);
      chk("t3_mnack_oe",    32'(cap_oe19),      32'd0);
      chk("t3_ack_error",   32'(bus.ack_error), 32'd0);
      chk("t3_addr_bits",   32'(cap_addr),      32'hA3);
      repeat (6) @(negedge clk);

      // start re-pulsed mid-address with different fields: must be ignored
      start_txn(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00);
      wait_slot(5);
      bus.addr  = 7'h7F;
      bus.wdata = 8'hFF;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done("t4");
      chk("t4_rises",     32'(rises),    32'd21);
      chk("t4_addr_bits", 32'(cap_addr), 32'hA0);
      chk("t4_data_bits", 32'(cap_data), 32'hA5);

      // back-to-back: start on the cycle right after done
      start_txn(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00);
      chk("t5_busy_after_start", 32'(bus.busy), 32'd1);
      wait_done("t5");
      chk("t5_rises",     32'(rises),    32'd21);
      chk("t5_addr_bits", 32'(cap_addr), 32'hA0);
      chk("t5_data_bits", 32'(cap_data), 32'hA5);
      repeat (4) @(negedge clk);

      // reset during WR bit 4 (0xA5 bit 4 is 0, so SDA is being pulled low)
      start_txn(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00);
      wait_slot(14);
      chk("t6_oe_before_rst", 32'(bus.sda_oe), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("t6_rst_sda_oe",      32'(bus.sda_oe),      32'd0);
      chk("t6_rst_scl_not_ena", 32'(bus.scl_not_ena), 32'd1);
      chk("t6_rst_busy",        32'(bus.busy),        32'd0);
      chk("t6_rst_done",        32'(bus.done),        32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      start_txn(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00);
      wait_done("t6");
      chk("t6_rises",     32'(rises),         32'd21);
      chk("t6_ack_error", 32'(bus.ack_error), 32'd0);
      chk("t6_data_bits", 32'(cap_data),      32'hA5);
      repeat (5) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
